cachepool_dram_interleaver: RTL and testbench

Sits between the cluster's wide AXI output (type `spatz_axi_out`: 32-bit address, 2-bit ID, 128-bit data) and the NumL2Channel DRAM controller ports. Steers each burst to one L2 channel by its interleave bits and compacts the address for that channel. Routes W beats after their AW, and merges B/R responses back with per-ID ordering protection.

---
 rtl/cachepool_pkg.sv | 107 ++++++++++
 rtl/cachepool_id_tracker.sv | 64 ++++++
 rtl/cachepool_dram_interleaver.sv | 224 ++++++++++++++++++++++
 tb/tb_cachepool_dram_interleaver.sv | 341 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cachepool_pkg.sv
// rtl/cachepool_pkg.sv - shared cachepool constants, wide AXI types and DRAM channel decode
//
// Purpose: cluster-level constants for the L2/DRAM side, the spatz_axi_out
//          request/response structs (32-bit addr, 2-bit ID, 128-bit data) and
//          dram_ch_decode(), which turns a cluster address into a DRAM channel
//          plus the address as seen by that channel.
// Ports:   none (package).
package cachepool_pkg;

  localparam int unsigned NumL2Channel  = 4;
  localparam int unsigned L2BankBeWidth = 64;   // bytes per L2 line
  localparam int unsigned Interleave    = 16;   // L2 lines per interleave chunk

  localparam int unsigned AddrWidth = 32;
  localparam int unsigned IdWidth   = 2;
  localparam int unsigned DataWidth = 128;
  localparam int unsigned StrbWidth = DataWidth / 8;

  // Chunk offset bits and channel-select bits above them.
  localparam int unsigned ChunkBits = $clog2(L2BankBeWidth * Interleave);
  localparam int unsigned SelBits   = $clog2(NumL2Channel);

  typedef logic [AddrWidth-1:0] addr_t;
  typedef logic [IdWidth-1:0]   id_t;

  typedef struct packed {
    id_t        id;
    addr_t      addr;
    logic [7:0] len;
    logic [2:0] size;
    logic [1:0] burst;
    logic       lock;
    logic [3:0] cache;
    logic [2:0] prot;
    logic [3:0] qos;
    logic [3:0] region;
    logic [5:0] atop;
  } spatz_axi_out_aw_chan_t;

  typedef struct packed {
    logic [DataWidth-1:0] data;
    logic [StrbWidth-1:0] strb;
    logic                 last;
  } spatz_axi_out_w_chan_t;

  typedef struct packed {
    id_t        id;
    logic [1:0] resp;
  } spatz_axi_out_b_chan_t;

  typedef struct packed {
    id_t        id;
    addr_t      addr;
    logic [7:0] len;
    logic [2:0] size;
    logic [1:0] burst;
    logic       lock;
    logic [3:0] cache;
    logic [2:0] prot;
    logic [3:0] qos;
    logic [3:0] region;
  } spatz_axi_out_ar_chan_t;

  typedef struct packed {
    id_t                  id;
    logic [DataWidth-1:0] data;
    logic [1:0]           resp;
    logic                 last;
  } spatz_axi_out_r_chan_t;

  typedef struct packed {
    spatz_axi_out_aw_chan_t aw;
    logic                   aw_valid;
    spatz_axi_out_w_chan_t  w;
    logic                   w_valid;
    logic                   b_ready;
    spatz_axi_out_ar_chan_t ar;
    logic                   ar_valid;
    logic                   r_ready;
  } spatz_axi_out_req_t;

  typedef struct packed {
    logic                  aw_ready;
    logic                  ar_ready;
    logic                  w_ready;
    logic                  b_valid;
    spatz_axi_out_b_chan_t b;
    logic                  r_valid;
    spatz_axi_out_r_chan_t r;
  } spatz_axi_out_resp_t;

  typedef struct packed {
    logic [SelBits-1:0] ch;
    addr_t              addr;
  } dram_dec_t;

  // Channel = the select bits just above the chunk offset. The channel-local
  // address zeroes those bits in place so each channel sees a sparse but
  // monotonic address space.
  function automatic dram_dec_t dram_ch_decode(input addr_t addr);
    dram_dec_t d;
    d.ch   = addr[ChunkBits+SelBits-1:ChunkBits];
    d.addr = {addr[AddrWidth-1:ChunkBits+SelBits], {SelBits{1'b0}}, addr[ChunkBits-1:0]};
    return d;
  endfunction

endpackage

// File: rtl/cachepool_id_tracker.sv
// rtl/cachepool_id_tracker.sv - per-ID outstanding counter and channel table with issue check
//
// Purpose: keeps, per AXI ID, the number of outstanding bursts and the channel
//          they went to. A new burst on an ID may issue only if nothing is
//          outstanding or it targets the same channel and the count is below
//          the limit, which keeps same-ID responses in order across channels.
// Ports:   clk_i, rst_i         clock, synchronous active-high reset
//          check_id, check_ch   candidate burst; can_issue is combinational
//          inc_valid/id/ch      burst issued (count up, record channel)
//          dec_valid/id         burst completed (count down)
module cachepool_id_tracker #(
  parameter int unsigned NumIds  = 4,
  parameter int unsigned MaxTxn  = 8,
  parameter int unsigned ChWidth = 2,
  localparam int unsigned IdW    = $clog2(NumIds),
  localparam int unsigned CntW   = $clog2(MaxTxn + 1)
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [IdW-1:0]     check_id,
  input  logic [ChWidth-1:0] check_ch,
  output logic               can_issue,
  input  logic               inc_valid,
  input  logic [IdW-1:0]     inc_id,
  input  logic [ChWidth-1:0] inc_ch,
  input  logic               dec_valid,
  input  logic [IdW-1:0]     dec_id
);

  logic [CntW-1:0]    cnt_q [NumIds];
  logic [ChWidth-1:0] ch_q  [NumIds];
  logic               dec_underflow;

  assign can_issue = (cnt_q[check_id] == '0) ||
                     ((cnt_q[check_id] < CntW'(MaxTxn)) && (ch_q[check_id] == check_ch));

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < NumIds; i++) begin
        cnt_q[i] <= '0;
        ch_q[i]  <= '0;
      end
    end else begin
      for (int i = 0; i < NumIds; i++) begin
        // Same-cycle issue and completion on one ID cancel in the count,
        // but the channel still follows the newly issued burst.
        if (inc_valid && (inc_id == IdW'(i)) && !(dec_valid && (dec_id == IdW'(i)))) begin
          cnt_q[i] <= cnt_q[i] + 1'b1;
        end else if (dec_valid && (dec_id == IdW'(i)) && !(inc_valid && (inc_id == IdW'(i)))) begin
          cnt_q[i] <= cnt_q[i] - 1'b1;
        end
        if (inc_valid && (inc_id == IdW'(i))) begin
          ch_q[i] <= inc_ch;
        end
      end
    end
  end

  // A response for an ID with nothing outstanding is a downstream protocol error.
  assign dec_underflow = dec_valid && (cnt_q[dec_id] == '0);

  a_no_underflow: assert property (@(posedge clk_i) disable iff (rst_i) !dec_underflow);

endmodule

// File: rtl/cachepool_dram_interleaver.sv
// rtl/cachepool_dram_interleaver.sv - steers wide AXI bursts to DRAM channels by interleave bits
//
// Purpose: routes each AW/AR burst whole to the channel picked by its start
//          address, compacts the address for that channel, forwards W beats
//          in AW order through a channel-select FIFO, and merges B/R back
//          with round-robin arbitration (R locked per burst). Per-ID trackers
//          stop an ID from having bursts in flight on two channels at once.
// Ports:   clk_i       clock
//          rst_i       synchronous active-high reset
//          slv_req_i   upstream request      slv_resp_o  upstream response
//          mst_req_o   per-channel requests  mst_resp_i  per-channel responses
module cachepool_dram_interleaver #(
  parameter int unsigned NumChannels = cachepool_pkg::NumL2Channel,
  parameter int unsigned Interleave  = cachepool_pkg::Interleave,
  parameter int unsigned LineBytes   = cachepool_pkg::L2BankBeWidth,
  parameter int unsigned MaxTxnPerId = 8,
  parameter int unsigned WFifoDepth  = 8
) (
  input  logic                               clk_i,
  input  logic                               rst_i,
  input  cachepool_pkg::spatz_axi_out_req_t  slv_req_i,
  output cachepool_pkg::spatz_axi_out_resp_t slv_resp_o,
  output cachepool_pkg::spatz_axi_out_req_t  mst_req_o  [NumChannels],
  input  cachepool_pkg::spatz_axi_out_resp_t mst_resp_i [NumChannels]
);
  import cachepool_pkg::*;

  localparam int unsigned ChW    = (NumChannels > 1) ? $clog2(NumChannels) : 1;
  localparam int unsigned CB     = $clog2(LineBytes * Interleave);
  localparam int unsigned FifoAw = $clog2(WFifoDepth);   // depth is a power of two
  localparam int unsigned NumIds = 2 ** IdWidth;

  typedef logic [ChW-1:0]    ch_t;
  typedef logic [FifoAw-1:0] fptr_t;
  typedef logic [FifoAw:0]   fcnt_t;

  // First requester at or after ptr, wrapping; ptr itself when none request.
  function automatic ch_t rr_pick(input logic [NumChannels-1:0] req, input ch_t ptr);
    ch_t g;
    ch_t idx;
    g = ptr;
    for (int k = NumChannels - 1; k >= 0; k--) begin
      idx = ptr + ch_t'(k);
      if (req[idx]) g = idx;
    end
    return g;
  endfunction

  // True when the burst stays inside one interleave chunk.
  function automatic logic in_chunk(input logic [CB-1:0] offs, input logic [7:0] len,
                                    input logic [2:0] size);
    logic [16:0] end_byte;
    end_byte = 17'(offs) + ((17'(len) + 17'd1) << size);
    return end_byte <= (17'd1 << CB);
  endfunction

  logic      run;
  dram_dec_t aw_dec, ar_dec;
  ch_t       aw_ch, ar_ch, w_ch;
  logic      aw_issue, ar_issue, aw_ok, ar_ok, w_ok;
  logic      aw_ready, ar_ready, w_ready;
  logic      aw_hs, ar_hs, w_pop, b_hs, r_hs;

  logic [NumChannels-1:0] b_req, r_req;
  ch_t  b_ptr, r_ptr, r_lock_ch, b_gnt, r_gnt;
  logic b_gnt_valid, r_gnt_valid, r_lock;

  ch_t   fifo_mem [WFifoDepth];
  fptr_t wr_ptr, rd_ptr;
  fcnt_t fifo_cnt;
  logic  fifo_full, fifo_empty;

  assign run    = !rst_i;
  assign aw_dec = dram_ch_decode(slv_req_i.aw.addr);
  assign ar_dec = dram_ch_decode(slv_req_i.ar.addr);
  assign aw_ch  = ch_t'(aw_dec.ch);
  assign ar_ch  = ch_t'(ar_dec.ch);

  // ---------------- AW / AR / W forward path ----------------
  assign fifo_full  = (fifo_cnt == fcnt_t'(WFifoDepth));
  assign fifo_empty = (fifo_cnt == '0);
  assign w_ch       = fifo_mem[rd_ptr];

  assign aw_ok    = run && aw_issue && !fifo_full;
  assign ar_ok    = run && ar_issue;
  assign w_ok     = run && !fifo_empty;   // no bypass: W waits for its AW to be stored
  assign aw_ready = aw_ok && mst_resp_i[aw_ch].aw_ready;
  assign ar_ready = ar_ok && mst_resp_i[ar_ch].ar_ready;
  assign w_ready  = w_ok && mst_resp_i[w_ch].w_ready;

  assign aw_hs = slv_req_i.aw_valid && aw_ready;
  assign ar_hs = slv_req_i.ar_valid && ar_ready;
  assign w_pop = slv_req_i.w_valid && w_ready && slv_req_i.w.last;

  // ---------------- B / R return arbitration ----------------
  always_comb begin
    b_req = '0;
    r_req = '0;
    for (int c = 0; c < NumChannels; c++) begin
      b_req[c] = mst_resp_i[c].b_valid;
      r_req[c] = mst_resp_i[c].r_valid;
    end
  end

  assign b_gnt       = rr_pick(b_req, b_ptr);
  assign b_gnt_valid = run && (|b_req);
  // While locked the R grant stays on one channel so a burst is never split.
  assign r_gnt       = r_lock ? r_lock_ch : rr_pick(r_req, r_ptr);
  assign r_gnt_valid = run && (r_lock ? r_req[r_lock_ch] : (|r_req));

  assign b_hs = b_gnt_valid && slv_req_i.b_ready;
  assign r_hs = r_gnt_valid && slv_req_i.r_ready;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      b_ptr     <= '0;
      r_ptr     <= '0;
      r_lock    <= 1'b0;
      r_lock_ch <= '0;
    end else begin
      if (b_hs) b_ptr <= b_gnt + 1'b1;
      if (r_hs) begin
        if (mst_resp_i[r_gnt].r.last) begin
          r_lock <= 1'b0;
          r_ptr  <= r_gnt + 1'b1;
        end else begin
          r_lock    <= 1'b1;
          r_lock_ch <= r_gnt;
        end
      end
    end
  end

  // ---------------- W channel-select FIFO ----------------
  always_ff @(posedge clk_i) begin
    if (aw_hs) fifo_mem[wr_ptr] <= aw_ch;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
    end else begin
      if (aw_hs) wr_ptr <= wr_ptr + 1'b1;
      if (w_pop) rd_ptr <= rd_ptr + 1'b1;
      case ({aw_hs, w_pop})
        2'b10:   fifo_cnt <= fifo_cnt + 1'b1;
        2'b01:   fifo_cnt <= fifo_cnt - 1'b1;
        default: fifo_cnt <= fifo_cnt;
      endcase
    end
  end

  // ---------------- per-ID ordering trackers ----------------
  cachepool_id_tracker #(
    .NumIds  (NumIds),
    .MaxTxn  (MaxTxnPerId),
    .ChWidth (ChW)
  ) i_w_tracker (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .check_id  (slv_req_i.aw.id),
    .check_ch  (aw_ch),
    .can_issue (aw_issue),
    .inc_valid (aw_hs),
    .inc_id    (slv_req_i.aw.id),
    .inc_ch    (aw_ch),
    .dec_valid (b_hs),
    .dec_id    (mst_resp_i[b_gnt].b.id)
  );

  cachepool_id_tracker #(
    .NumIds  (NumIds),
    .MaxTxn  (MaxTxnPerId),
    .ChWidth (ChW)
  ) i_r_tracker (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .check_id  (slv_req_i.ar.id),
    .check_ch  (ar_ch),
    .can_issue (ar_issue),
    .inc_valid (ar_hs),
    .inc_id    (slv_req_i.ar.id),
    .inc_ch    (ar_ch),
    .dec_valid (r_hs && mst_resp_i[r_gnt].r.last),
    .dec_id    (mst_resp_i[r_gnt].r.id)
  );

  // ---------------- output assembly ----------------
  always_comb begin
    for (int c = 0; c < NumChannels; c++) begin
      mst_req_o[c]          = '0;
      mst_req_o[c].aw       = slv_req_i.aw;
      mst_req_o[c].aw.addr  = aw_dec.addr;
      mst_req_o[c].aw_valid = slv_req_i.aw_valid && aw_ok && (aw_ch == ch_t'(c));
      mst_req_o[c].w        = slv_req_i.w;
      mst_req_o[c].w_valid  = slv_req_i.w_valid && w_ok && (w_ch == ch_t'(c));
      mst_req_o[c].ar       = slv_req_i.ar;
      mst_req_o[c].ar.addr  = ar_dec.addr;
      mst_req_o[c].ar_valid = slv_req_i.ar_valid && ar_ok && (ar_ch == ch_t'(c));
      mst_req_o[c].b_ready  = slv_req_i.b_ready && b_gnt_valid && (b_gnt == ch_t'(c));
      mst_req_o[c].r_ready  = slv_req_i.r_ready && r_gnt_valid && (r_gnt == ch_t'(c));
    end
  end

  always_comb begin
    slv_resp_o          = '0;
    slv_resp_o.aw_ready = aw_ready;
    slv_resp_o.ar_ready = ar_ready;
    slv_resp_o.w_ready  = w_ready;
    slv_resp_o.b_valid  = b_gnt_valid;
    slv_resp_o.b        = mst_resp_i[b_gnt].b;
    slv_resp_o.r_valid  = r_gnt_valid;
    slv_resp_o.r        = mst_resp_i[r_gnt].r;
  end

  // Bursts are routed whole; one crossing a chunk would straddle two channels.
  a_aw_in_chunk: assert property (@(posedge clk_i) disable iff (rst_i)
    slv_req_i.aw_valid |-> in_chunk(slv_req_i.aw.addr[CB-1:0], slv_req_i.aw.len, slv_req_i.aw.size));
  a_ar_in_chunk: assert property (@(posedge clk_i) disable iff (rst_i)
    slv_req_i.ar_valid |-> in_chunk(slv_req_i.ar.addr[CB-1:0], slv_req_i.ar.len, slv_req_i.ar.size));

endmodule

// File: tb/tb_cachepool_dram_interleaver.sv
// tb/tb_cachepool_dram_interleaver.sv - self-checking bench for cachepool_dram_interleaver
module tb_cachepool_dram_interleaver;
  import cachepool_pkg::*;

  localparam int NCh = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  spatz_axi_out_req_t  slv_req;
  spatz_axi_out_resp_t slv_resp;
  spatz_axi_out_req_t  mst_req  [NCh];
  spatz_axi_out_resp_t mst_resp [NCh];

  int checks = 0;
  int passed = 0;

  always #5 clk = ~clk;

  cachepool_dram_interleaver dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .slv_req_i  (slv_req),
    .slv_resp_o (slv_resp),
    .mst_req_o  (mst_req),
    .mst_resp_i (mst_resp)
  );

  typedef struct {
    logic [31:0] addr;
    int          ch;
    logic [31:0] exp_addr;
  } vec_t;

  vec_t vecs [7];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    slv_req = '0;
    slv_req.aw.size = 3'd4;
    slv_req.ar.size = 3'd4;
    for (int c = 0; c < NCh; c++) mst_resp[c] = '0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    clear_inputs();
    tick();
    tick();
    rst = 1'b0;
  endtask

  function automatic logic [3:0] ar_vec();
    logic [3:0] v;
    for (int c = 0; c < NCh; c++) v[c] = mst_req[c].ar_valid;
    return v;
  endfunction

  function automatic logic [3:0] aw_vec();
    logic [3:0] v;
    for (int c = 0; c < NCh; c++) v[c] = mst_req[c].aw_valid;
    return v;
  endfunction

  function automatic logic [3:0] w_vec();
    logic [3:0] v;
    for (int c = 0; c < NCh; c++) v[c] = mst_req[c].w_valid;
    return v;
  endfunction

  function automatic logic [24:0] vr_bits();
    logic [24:0] v;
    v = '0;
    v[4:0] = {slv_resp.aw_ready, slv_resp.ar_ready, slv_resp.w_ready,
              slv_resp.b_valid, slv_resp.r_valid};
    for (int c = 0; c < NCh; c++)
      v[5+c*5 +: 5] = {mst_req[c].aw_valid, mst_req[c].w_valid, mst_req[c].ar_valid,
                       mst_req[c].b_ready, mst_req[c].r_ready};
    return v;
  endfunction

  task automatic drive_all_valid();
    slv_req.aw_valid = 1'b1;
    slv_req.w_valid  = 1'b1;
    slv_req.ar_valid = 1'b1;
    slv_req.b_ready  = 1'b1;
    slv_req.r_ready  = 1'b1;
    for (int c = 0; c < NCh; c++) begin
      mst_resp[c].aw_ready = 1'b1;
      mst_resp[c].ar_ready = 1'b1;
      mst_resp[c].w_ready  = 1'b1;
      mst_resp[c].b_valid  = 1'b1;
      mst_resp[c].r_valid  = 1'b1;
    end
  endtask

  initial begin
    int beats [NCh];
    int hs_c;

    vecs[0] = '{32'h8000_0400, 1, 32'h8000_0000};
    vecs[1] = '{32'h8000_0C00, 3, 32'h8000_0000};
    vecs[2] = '{32'h8000_0000, 0, 32'h8000_0000};
    vecs[3] = '{32'h8000_0800, 2, 32'h8000_0000};
    vecs[4] = '{32'h1234_5678, 1, 32'h1234_5278};
    vecs[5] = '{32'hFFFF_FFF0, 3, 32'hFFFF_F3F0};
    vecs[6] = '{32'h0000_1C40, 3, 32'h0000_1040};

    // Reset: every valid/ready output low even with all inputs active.
    clear_inputs();
    drive_all_valid();
    #1 chk("reset_outputs_t0", 128'(vr_bits()), 128'h0);
    tick();
    chk("reset_outputs_t1", 128'(vr_bits()), 128'h0);
    do_reset();

    // Decode table: channel selection and address compaction (no handshake).
    for (int i = 0; i < 7; i++) begin
      slv_req.ar_valid = 1'b1;
      slv_req.ar.addr  = vecs[i].addr;
      slv_req.ar.len   = 8'd0;
      #1;
      chk($sformatf("dec_ch_%0d", i), 128'(ar_vec()), 128'(4'b1 << vecs[i].ch));
      chk($sformatf("dec_addr_%0d", i), 128'(mst_req[vecs[i].ch].ar.addr), 128'(vecs[i].exp_addr));
    end
    do_reset();

    // AR to channel 1, R returns upstream.
    for (int c = 0; c < NCh; c++) mst_resp[c].ar_ready = 1'b1;
    slv_req.ar_valid = 1'b1;
    slv_req.ar.addr  = 32'h8000_0400;
    #1;
    chk("ar1_ready", 128'(slv_resp.ar_ready), 128'h1);
    chk("ar1_ch", 128'(ar_vec()), 128'h2);
    chk("ar1_addr", 128'(mst_req[1].ar.addr), 128'h8000_0000);
    tick();
    slv_req.ar_valid = 1'b0;
    mst_resp[1].r_valid = 1'b1;
    mst_resp[1].r.id    = 2'd0;
    mst_resp[1].r.last  = 1'b1;
    mst_resp[1].r.data  = 128'hABCD_0123;
    slv_req.r_ready     = 1'b1;
    #1;
    chk("r1_valid", 128'(slv_resp.r_valid), 128'h1);
    chk("r1_data", slv_resp.r.data, 128'hABCD_0123);
    chk("r1_ready_ch1", 128'(mst_req[1].r_ready), 128'h1);
    tick();
    do_reset();

    // Same ID to a different channel stalls until the first burst completes.
    for (int c = 0; c < NCh; c++) mst_resp[c].ar_ready = 1'b1;
    slv_req.ar_valid = 1'b1;
    slv_req.ar.id    = 2'd2;
    slv_req.ar.addr  = 32'h8000_0C00;
    #1 chk("ar2a_ch", 128'(ar_vec()), 128'h8);
    tick();
    slv_req.ar.addr = 32'h8000_0000;
    #1;
    chk("ar2b_stall_ready", 128'(slv_resp.ar_ready), 128'h0);
    chk("ar2b_stall_valid", 128'(ar_vec()), 128'h0);
    tick();
    chk("ar2b_stall_hold", 128'(slv_resp.ar_ready), 128'h0);
    mst_resp[3].r_valid = 1'b1;
    mst_resp[3].r.id    = 2'd2;
    mst_resp[3].r.last  = 1'b1;
    slv_req.r_ready     = 1'b1;
    #1 chk("ar2b_stall_rlast_cycle", 128'(slv_resp.ar_ready), 128'h0);
    tick();
    mst_resp[3].r_valid = 1'b0;
    #1;
    chk("ar2b_release_ready", 128'(slv_resp.ar_ready), 128'h1);
    chk("ar2b_release_ch", 128'(ar_vec()), 128'h1);
    slv_req.ar_valid = 1'b0;
    do_reset();

    // AW to ch2 then ch3 (len3 each); W routed by AW order.
    for (int c = 0; c < NCh; c++) begin
      mst_resp[c].aw_ready = 1'b1;
      mst_resp[c].w_ready  = 1'b1;
    end
    slv_req.w_valid = 1'b1;
    #1 chk("w_before_aw_ready", 128'(slv_resp.w_ready), 128'h0);
    slv_req.aw_valid = 1'b1;
    slv_req.aw.addr  = 32'h8000_0800;
    slv_req.aw.len   = 8'd3;
    #1;
    chk("aw_ch2", 128'(aw_vec()), 128'h4);
    chk("aw_ch2_addr", 128'(mst_req[2].aw.addr), 128'h8000_0000);
    chk("w_no_bypass", 128'(slv_resp.w_ready), 128'h0);
    slv_req.w_valid = 1'b0;
    tick();
    slv_req.aw.id   = 2'd1;
    slv_req.aw.addr = 32'h8000_0C00;
    #1 chk("aw_ch3", 128'(aw_vec()), 128'h8);
    tick();
    slv_req.aw_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      slv_req.w_valid = 1'b1;
      slv_req.w.data  = 128'(i);
      slv_req.w.last  = (i % 4 == 3);
      #1;
      chk($sformatf("w_beat%0d_ch", i), 128'(w_vec()), (i < 4) ? 128'h4 : 128'h8);
      chk($sformatf("w_beat%0d_ready", i), 128'(slv_resp.w_ready), 128'h1);
      tick();
    end
    chk("w_fifo_empty_ready", 128'(slv_resp.w_ready), 128'h0);
    chk("w_fifo_empty_valid", 128'(w_vec()), 128'h0);
    slv_req.w_valid = 1'b0;
    mst_resp[2].b_valid = 1'b1;
    mst_resp[2].b.id    = 2'd0;
    mst_resp[3].b_valid = 1'b1;
    mst_resp[3].b.id    = 2'd1;
    slv_req.b_ready     = 1'b1;
    #1;
    chk("b_first_id", 128'(slv_resp.b.id), 128'h0);
    chk("b_first_ready_ch2", 128'(mst_req[2].b_ready), 128'h1);
    tick();
    mst_resp[2].b_valid = 1'b0;
    #1 chk("b_second_id", 128'(slv_resp.b.id), 128'h1);
    tick();
    do_reset();

    // W FIFO full holds AW; one W last frees a slot for the next cycle.
    for (int c = 0; c < NCh; c++) begin
      mst_resp[c].aw_ready = 1'b1;
      mst_resp[c].w_ready  = 1'b1;
    end
    slv_req.aw_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      slv_req.aw.id   = (i < 4) ? 2'd0 : 2'd1;
      slv_req.aw.addr = (i < 4) ? 32'h8000_0000 : 32'h8000_0400;
      tick();
    end
    slv_req.aw.id   = 2'd2;
    slv_req.aw.addr = 32'h8000_0800;
    #1 chk("fifo_full_aw_held", 128'(slv_resp.aw_ready), 128'h0);
    slv_req.w_valid = 1'b1;
    slv_req.w.last  = 1'b1;
    #1 chk("fifo_full_aw_held_pop_cycle", 128'(slv_resp.aw_ready), 128'h0);
    tick();
    slv_req.w_valid = 1'b0;
    #1;
    chk("fifo_slot_aw_ready", 128'(slv_resp.aw_ready), 128'h1);
    chk("fifo_slot_aw_ch", 128'(aw_vec()), 128'h4);
    slv_req.aw_valid = 1'b0;
    do_reset();

    // 9 ARs on id1 to ch0: the 9th stalls until one rlast.
    for (int c = 0; c < NCh; c++) mst_resp[c].ar_ready = 1'b1;
    slv_req.ar_valid = 1'b1;
    slv_req.ar.id    = 2'd1;
    slv_req.ar.addr  = 32'h8000_0000;
    for (int i = 0; i < 8; i++) tick();
    chk("ar9_stall", 128'(slv_resp.ar_ready), 128'h0);
    chk("ar9_stall_valid", 128'(ar_vec()), 128'h0);
    mst_resp[0].r_valid = 1'b1;
    mst_resp[0].r.id    = 2'd1;
    mst_resp[0].r.last  = 1'b1;
    slv_req.r_ready     = 1'b1;
    #1 chk("ar9_stall_rlast_cycle", 128'(slv_resp.ar_ready), 128'h0);
    tick();
    mst_resp[0].r_valid = 1'b0;
    #1 chk("ar9_release", 128'(slv_resp.ar_ready), 128'h1);
    slv_req.ar_valid = 1'b0;
    do_reset();

    // Round-robin R over four len1 bursts: 0,1,2,3 with no beat interleave.
    for (int c = 0; c < NCh; c++) mst_resp[c].ar_ready = 1'b1;
    for (int c = 0; c < NCh; c++) begin
      slv_req.ar_valid = 1'b1;
      slv_req.ar.id    = 2'(c);
      slv_req.ar.addr  = 32'h8000_0000 + 32'(c) * 32'h400;
      slv_req.ar.len   = 8'd1;
      tick();
    end
    slv_req.ar_valid = 1'b0;
    slv_req.r_ready  = 1'b1;
    for (int c = 0; c < NCh; c++) beats[c] = 0;
    for (int i = 0; i < 8; i++) begin
      for (int c = 0; c < NCh; c++) begin
        mst_resp[c].r_valid = (beats[c] < 2);
        mst_resp[c].r.id    = 2'(c);
        mst_resp[c].r.data  = 128'(c * 16 + beats[c]);
        mst_resp[c].r.last  = (beats[c] == 1);
      end
      #1;
      chk($sformatf("rr_beat%0d", i), {127'(slv_resp.r.data), slv_resp.r_valid},
          {127'((i / 2) * 16 + (i % 2)), 1'b1});
      hs_c = -1;
      for (int c = 0; c < NCh; c++)
        if (mst_req[c].r_ready && mst_resp[c].r_valid) hs_c = c;
      tick();
      if (hs_c >= 0) beats[hs_c]++;
    end
    for (int c = 0; c < NCh; c++) mst_resp[c].r_valid = 1'b0;
    #1 chk("rr_done", 128'(slv_resp.r_valid), 128'h0);
    do_reset();

    // Reset in the middle of a write burst clears counters and FIFO.
    for (int c = 0; c < NCh; c++) begin
      mst_resp[c].aw_ready = 1'b1;
      mst_resp[c].w_ready  = 1'b1;
    end
    slv_req.aw_valid = 1'b1;
    slv_req.aw.addr  = 32'h8000_0400;
    slv_req.aw.len   = 8'd3;
    tick();
    slv_req.aw_valid = 1'b0;
    slv_req.w_valid  = 1'b1;
    tick();
    tick();
    rst = 1'b1;
    slv_req.aw_valid = 1'b1;
    slv_req.aw.addr  = 32'h8000_0000;
    #1 chk("midburst_reset_outputs", 128'(vr_bits()), 128'h0);
    tick();
    rst = 1'b0;
    #1;
    chk("post_reset_w_ready", 128'(slv_resp.w_ready), 128'h0);
    chk("post_reset_aw_ready", 128'(slv_resp.aw_ready), 128'h1);
    chk("post_reset_aw_ch", 128'(aw_vec()), 128'h1);
    tick();
    slv_req.aw_valid = 1'b0;
    #1 chk("post_reset_w_ch0", 128'(w_vec()), 128'h1);
    slv_req.w_valid = 1'b0;
    tick();

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
